// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity encoder/decoder pair.
package parity_pkg;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

  // Frame length: data bits plus one trailing parity bit.
  function automatic int unsigned frame_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

  // Width of a counter that indexes every bit position of a frame.
  function automatic int unsigned cnt_w(input int unsigned data_w);
    return $clog2(frame_w(data_w));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at its maximum value.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on request unless already saturated at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/parity_decoder.sv
// Serial frame receiver: MSB-first data bits then one parity bit per frame.
module parity_decoder
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 15,
  parameter int unsigned ODD_PARITY = PAR_EVEN,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic                din_valid,
  input  logic                sof,
  output logic [DATA_W-1:0]   data_out,
  output logic                out_valid,
  output logic                parity_err,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                busy
);

  localparam int unsigned FRAME_W = frame_w(DATA_W);
  localparam int unsigned CNT_W   = cnt_w(DATA_W);
  localparam int unsigned LAST    = FRAME_W - 1;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;

  logic bit0_c;
  logic last_c;
  logic err_c;
  logic bad_frame_c;

  // Frame position decode; sof forces bit 0 and overrides a pending parity slot.
  always_comb begin
    bit0_c      = sof || (cnt == '0);
    last_c      = !sof && (cnt == CNT_W'(LAST));
    err_c       = par ^ din ^ 1'(ODD_PARITY);
    bad_frame_c = din_valid && last_c && err_c;
  end

  // Shift/parity datapath and frame completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (din_valid) begin
        if (last_c) begin
          data_out   <= shreg;
          out_valid  <= 1'b1;
          parity_err <= err_c;
          par        <= par ^ din;
          cnt        <= '0;
          busy       <= 1'b0;
        end else begin
          shreg <= {shreg[DATA_W-2:0], din};
          par   <= bit0_c ? din : (par ^ din);
          cnt   <= bit0_c ? CNT_W'(1) : (cnt + CNT_W'(1));
          busy  <= 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .W (ERRCNT_W)
  ) u_errcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bad_frame_c),
    .count (err_count)
  );

endmodule

// File: tb/tb_parity_decoder.sv
// Bench for parity_decoder: default, 2-bit error counter and odd-parity instances.
module tb_parity_decoder;

  logic clk = 1'b0;
  logic rst_n, din, din_valid, sof;

  logic [14:0] data0, data1, data2;
  logic        ov0, ov1, ov2;
  logic        pe0, pe1, pe2;
  logic [7:0]  ec0, ec2;
  logic [1:0]  ec1;
  logic        busy0, busy1, busy2;

  int errors = 0;
  int checks = 0;
  int pulses0 = 0;
  int model_ec0, model_ec1, model_ec2;

  typedef struct {
    logic [14:0] data;
    logic        err_even;
    logic        err_odd;
    int          cnt0;
    int          cnt1;
    int          cnt2;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  parity_decoder #(.DATA_W(15), .ODD_PARITY(0), .ERRCNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .data_out(data0), .out_valid(ov0), .parity_err(pe0), .err_count(ec0), .busy(busy0));

  parity_decoder #(.DATA_W(15), .ODD_PARITY(0), .ERRCNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .data_out(data1), .out_valid(ov1), .parity_err(pe1), .err_count(ec1), .busy(busy1));

  parity_decoder #(.DATA_W(15), .ODD_PARITY(1), .ERRCNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .data_out(data2), .out_valid(ov2), .parity_err(pe2), .err_count(ec2), .busy(busy2));

  // Count out_valid pulses of the main instance.
  always @(posedge clk) begin
    if (ov0) pulses0 <= pulses0 + 1;
  end

  task automatic apply_reset();
    din = 1'b0; din_valid = 1'b0; sof = 1'b0;
    rst_n = 1'b0;
    model_ec0 = 0; model_ec1 = 0; model_ec2 = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_bit(input logic b, input logic s);
    @(negedge clk);
    din = b; din_valid = 1'b1; sof = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [14:0] d, input logic p, input logic first_sof);
    for (int i = 14; i >= 0; i--) drive_bit(d[i], (i == 14) && first_sof);
    drive_bit(p, 1'b0);
  endtask

  // Bench model: expected error flags and saturating counts, queued at drive time.
  task automatic push_exp(input logic [14:0] d, input logic p);
    exp_t e;
    e.data     = d;
    e.err_even = ^{d, p};
    e.err_odd  = ~(^{d, p});
    if (e.err_even && model_ec0 < 255) model_ec0++;
    if (e.err_even && model_ec1 < 3)   model_ec1++;
    if (e.err_odd  && model_ec2 < 255) model_ec2++;
    e.cnt0 = model_ec0; e.cnt1 = model_ec1; e.cnt2 = model_ec2;
    sbq.push_back(e);
  endtask

  // Bounded wait for out_valid of instance 0/1/2.
  task automatic wait_valid(input int which, output bit got);
    int k;
    logic v;
    got = 1'b0;
    k = 0;
    while (!got && k < 4) begin
      v = (which == 0) ? ov0 : (which == 1) ? ov1 : ov2;
      if (v === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; k++; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (data0 !== 15'h0 || ov0 !== 1'b0 || pe0 !== 1'b0) begin
      errors++; $display("FAIL reset_dout: data=%h ov=%b pe=%b want 0/0/0", data0, ov0, pe0);
    end
    checks++;
    if (ec0 !== 8'h0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: ec=%0d busy=%b want 0/0", ec0, busy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    exp_t e;
    bit got;
    apply_reset();
    push_exp(15'h1697, 1'b0);
    send_frame(15'h1697, 1'b0, 1'b0);
    wait_valid(0, got);
    e = sbq.pop_front();
    checks++;
    if (!got) begin errors++; $display("FAIL good_valid: out_valid never rose, want 1"); end
    checks++;
    if (data0 !== e.data || data0 !== 15'h1697) begin
      errors++; $display("FAIL good_data: got %h want %h", data0, 15'h1697);
    end
    checks++;
    if (pe0 !== e.err_even || ec0 !== 8'(e.cnt0) || pe0 !== 1'b0) begin
      errors++; $display("FAIL good_err: pe=%b ec=%0d want 0/0", pe0, ec0);
    end
    idle(1);
    checks++;
    if (ov0 !== 1'b0 || data0 !== 15'h1697) begin
      errors++; $display("FAIL good_pulse: ov=%b data=%h want 0/1697", ov0, data0);
    end
  endtask

  task automatic test_corrupt();
    exp_t e;
    bit got;
    push_exp(15'h1697, 1'b1);
    send_frame(15'h1697, 1'b1, 1'b0);
    wait_valid(0, got);
    e = sbq.pop_front();
    checks++;
    if (!got || data0 !== e.data) begin
      errors++; $display("FAIL bad_data: ov=%b data=%h want 1/%h", got, data0, e.data);
    end
    checks++;
    if (pe0 !== 1'b1 || ec0 !== 8'(e.cnt0) || ec0 !== 8'd1) begin
      errors++; $display("FAIL bad_err: pe=%b ec=%0d want 1/1", pe0, ec0);
    end
  endtask

  task automatic test_gapped();
    exp_t e;
    bit got;
    logic [14:0] d;
    d = 15'h7FFF;
    push_exp(d, 1'b1);
    for (int i = 14; i >= 0; i--) begin
      drive_bit(d[i], 1'b0);
      idle(3);
      checks++;
      if (ov0 !== 1'b0 || busy0 !== 1'b1) begin
        errors++; $display("FAIL gap_bit%0d: ov=%b busy=%b want 0/1", 14 - i, ov0, busy0);
      end
    end
    drive_bit(1'b1, 1'b0);
    wait_valid(0, got);
    e = sbq.pop_front();
    checks++;
    if (!got || data0 !== e.data || pe0 !== e.err_even || pe0 !== 1'b0) begin
      errors++; $display("FAIL gap_frame: ov=%b data=%h pe=%b want 1/7fff/0", got, data0, pe0);
    end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL gap_busy_end: busy=%b want 0", busy0); end
  endtask

  task automatic test_resync();
    exp_t e;
    bit got;
    int p_before;
    logic [6:0] junk;
    junk = 7'b1011001;
    for (int i = 6; i >= 0; i--) drive_bit(junk[i], i == 6);
    p_before = pulses0;
    push_exp(15'h0001, 1'b1);
    send_frame(15'h0001, 1'b1, 1'b1);
    wait_valid(0, got);
    e = sbq.pop_front();
    checks++;
    if (!got || data0 !== 15'h0001 || pe0 !== e.err_even || pe0 !== 1'b0) begin
      errors++; $display("FAIL resync_frame: ov=%b data=%h pe=%b want 1/0001/0", got, data0, pe0);
    end
    checks++;
    if (ec0 !== 8'(e.cnt0) || ec0 !== 8'd1) begin
      errors++; $display("FAIL resync_cnt: ec=%0d want 1", ec0);
    end
    idle(1);
    checks++;
    if (pulses0 - p_before !== 1) begin
      errors++; $display("FAIL resync_pulses: got %0d want 1", pulses0 - p_before);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    bit got;
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      push_exp(15'h1697, 1'b1);
      send_frame(15'h1697, 1'b1, 1'b0);
      wait_valid(1, got);
      e = sbq.pop_front();
      checks++;
      if (!got || pe1 !== 1'b1 || int'(ec1) != sat_exp[f] || int'(ec1) != e.cnt1) begin
        errors++; $display("FAIL sat_frame%0d: ov=%b pe=%b ec=%0d want 1/1/%0d", f, got, pe1, ec1, sat_exp[f]);
      end
    end
    for (int i = 0; i < 7; i++) drive_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_ec0 = 0; model_ec1 = 0; model_ec2 = 0;
    #1;
    checks++;
    if (data1 !== 15'h0 || ov1 !== 1'b0 || pe1 !== 1'b0 || ec1 !== 2'd0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL sat_reset: data=%h ov=%b pe=%b ec=%0d busy=%b want all 0", data1, ov1, pe1, ec1, busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(15'h0001, 1'b1);
    send_frame(15'h0001, 1'b1, 1'b0);
    wait_valid(1, got);
    e = sbq.pop_front();
    checks++;
    if (!got || data1 !== e.data || pe1 !== 1'b0 || ec1 !== 2'd0) begin
      errors++; $display("FAIL sat_after_reset: ov=%b data=%h pe=%b ec=%0d want 1/0001/0/0", got, data1, pe1, ec1);
    end
  endtask

  task automatic test_odd();
    exp_t e;
    bit got;
    apply_reset();
    push_exp(15'h0000, 1'b1);
    send_frame(15'h0000, 1'b1, 1'b0);
    wait_valid(2, got);
    e = sbq.pop_front();
    checks++;
    if (!got || pe2 !== e.err_odd || pe2 !== 1'b0 || ec2 !== 8'd0) begin
      errors++; $display("FAIL odd_good: ov=%b pe=%b ec=%0d want 1/0/0", got, pe2, ec2);
    end
    push_exp(15'h0000, 1'b0);
    send_frame(15'h0000, 1'b0, 1'b0);
    wait_valid(2, got);
    e = sbq.pop_front();
    checks++;
    if (!got || pe2 !== 1'b1 || ec2 !== 8'(e.cnt2) || ec2 !== 8'd1 || data2 !== 15'h0) begin
      errors++; $display("FAIL odd_bad: ov=%b pe=%b ec=%0d data=%h want 1/1/1/0000", got, pe2, ec2, data2);
    end
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
    test_reset();
    test_good_frame();
    test_corrupt();
    test_gapped();
    test_resync();
    test_saturation();
    test_odd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
